// File: rtl/companion_stat_driver.sv
// companion_stat_driver: periodic decay tick, debounced care-button refresh pulses
// and hysteretic mood classification for one companion stat register.
module companion_stat_driver #(
  parameter int TICK_PERIOD     = 50000000,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int LOW_THRESHOLD   = 3,
  parameter int MAX_VALUE       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        care_btn,
  input  logic        pause,
  input  logic [31:0] value,
  output logic        tick,
  output logic        refresh,
  output logic [1:0]  status,
  output logic        alert,
  output logic [15:0] refresh_count
);

  typedef enum logic [1:0] {
    MOOD_OK    = 2'b00,
    MOOD_LOW   = 2'b01,
    MOOD_EMPTY = 2'b10
  } mood_t;

  localparam int TICK_W = $clog2(TICK_PERIOD);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CD_W   = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
  localparam logic [DB_W-1:0]   DB_FULL   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_ARM    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN_CYCLES);
  localparam logic [31:0]       LOW_V     = 32'(LOW_THRESHOLD);
  localparam logic [31:0]       RECOVER_V = 32'(LOW_THRESHOLD + 2);
  localparam logic [31:0]       MAX_V     = 32'(MAX_VALUE);

  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_r;
  logic [1:0]        sync_r;
  logic [DB_W-1:0]   db_cnt_r;
  logic              press_r;
  logic [CD_W-1:0]   cd_cnt_r;
  logic              defer_r;
  logic              refresh_r;
  logic [15:0]       count_r;
  mood_t             mood_r;
  logic              alert_r;

  logic              tick_wrap_s;
  logic              req_s;
  logic              fire_s;
  mood_t             mood_next_s;

  // Out-of-range readings count as healthy; LOW leaves only at threshold+2 (hysteresis).
  function automatic mood_t mood_next(input mood_t cur, input logic [31:0] v);
    mood_t nxt;
    if (v == 32'd0) begin
      nxt = MOOD_EMPTY;
    end else if (v > MAX_V) begin
      nxt = MOOD_OK;
    end else begin
      case (cur)
        MOOD_OK:    nxt = (v <= LOW_V) ? MOOD_LOW : MOOD_OK;
        MOOD_LOW:   nxt = (v >= RECOVER_V) ? MOOD_OK : MOOD_LOW;
        MOOD_EMPTY: nxt = (v >= RECOVER_V) ? MOOD_OK : MOOD_LOW;
        default:    nxt = MOOD_OK;
      endcase
    end
    return nxt;
  endfunction

  // Event qualification: timer wrap, cooldown-gated request, refresh candidate, next mood.
  always_comb begin
    tick_wrap_s = 1'b0;
    req_s       = 1'b0;
    if (!pause && (tick_cnt_r == TICK_LAST)) begin
      tick_wrap_s = 1'b1;
    end else begin
      tick_wrap_s = 1'b0;
    end
    if (press_r && (cd_cnt_r == {CD_W{1'b0}})) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    fire_s      = req_s | defer_r;
    mood_next_s = mood_next(mood_r, value);
  end

  // Decay timer: frozen while paused so a pause stretches the period without losing ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      tick_r     <= 1'b0;
    end else begin
      tick_r <= tick_wrap_s;
      if (pause) begin
        tick_cnt_r <= tick_cnt_r;
      end else if (tick_wrap_s) begin
        tick_cnt_r <= {TICK_W{1'b0}};
      end else begin
        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      end
    end
  end

  // Button synchronizer and saturating debounce; one press per held level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r   <= 2'b00;
      db_cnt_r <= {DB_W{1'b0}};
      press_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], care_btn};
      press_r <= sync_r[1] && (db_cnt_r == DB_ARM);
      if (!sync_r[1]) begin
        db_cnt_r <= {DB_W{1'b0}};
      end else if (db_cnt_r != DB_FULL) begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end else begin
        db_cnt_r <= db_cnt_r;
      end
    end
  end

  // Cooldown after each granted request; presses seen while nonzero are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_cnt_r <= {CD_W{1'b0}};
    end else if (req_s) begin
      cd_cnt_r <= CD_LOAD;
    end else if (cd_cnt_r != {CD_W{1'b0}}) begin
      cd_cnt_r <= cd_cnt_r - CD_W'(1);
    end else begin
      cd_cnt_r <= cd_cnt_r;
    end
  end

  // Refresh issue: a request colliding with a tick slips one cycle (ticks never repeat back to back).
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_r <= 1'b0;
      defer_r   <= 1'b0;
      count_r   <= 16'h0000;
    end else begin
      refresh_r <= fire_s & ~tick_wrap_s;
      defer_r   <= fire_s & tick_wrap_s;
      if (refresh_r && (count_r != 16'hFFFF)) begin
        count_r <= count_r + 16'h0001;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Mood state and entry-to-EMPTY alert.
  always_ff @(posedge clk) begin
    if (rst) begin
      mood_r  <= MOOD_OK;
      alert_r <= 1'b0;
    end else begin
      mood_r  <= mood_next_s;
      alert_r <= (mood_next_s == MOOD_EMPTY) && (mood_r != MOOD_EMPTY);
    end
  end

  assign tick          = tick_r;
  assign refresh       = refresh_r;
  assign status        = mood_r;
  assign alert         = alert_r;
  assign refresh_count = count_r;

endmodule

// File: tb/tb_companion_stat_driver.sv
// Bench for companion_stat_driver: event-level reference model checked every cycle,
// directed scenarios pinned with hand-computed cycle numbers, then random stimulus.
module tb_companion_stat_driver;
  localparam int P  = 5;
  localparam int D  = 4;
  localparam int C  = 8;
  localparam int LT = 3;
  localparam int MX = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        care_btn = 1'b0;
  logic        pause = 1'b0;
  logic [31:0] value = 32'd10;
  logic        tick;
  logic        refresh;
  logic [1:0]  status;
  logic        alert;
  logic [15:0] refresh_count;

  companion_stat_driver #(
    .TICK_PERIOD(P), .DEBOUNCE_CYCLES(D), .COOLDOWN_CYCLES(C),
    .LOW_THRESHOLD(LT), .MAX_VALUE(MX)
  ) dut (
    .clk(clk), .rst(rst), .care_btn(care_btn), .pause(pause), .value(value),
    .tick(tick), .refresh(refresh), .status(status), .alert(alert),
    .refresh_count(refresh_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state (edge-indexed events)
  int  unpaused = 0;
  int  run = 0;
  int  last_req = 0;
  bit  have_req = 1'b0;
  bit  deferred = 1'b0;
  int  reach_q[$];
  bit  m_tick = 1'b0;
  bit  m_ref = 1'b0;
  bit  m_alert = 1'b0;
  int  m_status = 0;
  int  m_count = 0;

  int  tick_edges[$];
  int  ref_edges[$];

  int  pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
  int  mv  [12] = '{10, 3, 4, 5, 0, 2, 4, 0, 4, 5, 4, 200};
  int  ms  [12] = '{0, 1, 1, 0, 2, 1, 1, 2, 1, 0, 0, 0};
  int  ma  [12] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // 0 OK, 1 LOW, 2 EMPTY
  function automatic int mood_rule(input int cur, input logic [31:0] v);
    if (v == 32'd0) return 2;
    if (v > 32'(MX)) return 0;
    if (cur == 0) return (v <= 32'(LT)) ? 1 : 0;
    return (v >= 32'(LT + 2)) ? 0 : 1;
  endfunction

  // model update on every edge, then compare just after it
  always @(posedge clk) begin
    bit accepted;
    int nxt;
    cyc++;
    if (rst) begin
      unpaused = 0; run = 0; have_req = 1'b0; deferred = 1'b0; reach_q.delete();
      m_tick = 1'b0; m_ref = 1'b0; m_alert = 1'b0; m_status = 0; m_count = 0;
    end else begin
      if (m_ref && m_count < 65535) m_count++;
      if (!pause) begin
        unpaused++;
        m_tick = (unpaused % P == 0);
      end else begin
        m_tick = 1'b0;
      end
      if (care_btn) run++;
      else run = 0;
      if (run == D) reach_q.push_back(cyc);
      accepted = 1'b0;
      if (reach_q.size() > 0 && reach_q[0] + 3 == cyc) begin
        void'(reach_q.pop_front());
        if (!have_req || (cyc - last_req >= C + 1)) begin
          accepted = 1'b1; have_req = 1'b1; last_req = cyc;
        end
      end
      m_ref = deferred;
      deferred = 1'b0;
      if (accepted) begin
        if (m_tick) deferred = 1'b1;
        else m_ref = 1'b1;
      end
      nxt = mood_rule(m_status, value);
      m_alert = (nxt == 2) && (m_status != 2);
      m_status = nxt;
    end
    #1;
    check("tick", tick, m_tick);
    check("refresh", refresh, m_ref);
    check("status", status, m_status);
    check("alert", alert, m_alert);
    check("refresh_count", refresh_count, m_count);
    check("tick_refresh_exclusive", tick & refresh, 0);
    if (tick === 1'b1) tick_edges.push_back(cyc);
    if (refresh === 1'b1) ref_edges.push_back(cyc);
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = cyc;

    // ticks at 5, 10, 15 after reset release
    repeat (15) @(negedge clk);
    check("p1_tick_events", tick_edges.size(), 3);
    for (int i = 0; i < 3; i++)
      check("p1_tick_cycle", (i < tick_edges.size()) ? tick_edges[i] - base : -1, 5 * (i + 1));
    check("p1_count", refresh_count, 0);

    // clean press held 20 cycles: E0=16, refresh at 22
    ref_edges.delete();
    care_btn = 1'b1;
    repeat (20) @(negedge clk);
    care_btn = 1'b0;
    check("p2_refresh_events", ref_edges.size(), 1);
    check("p2_refresh_cycle", (ref_edges.size() > 0) ? ref_edges[0] - base : -1, 22);
    check("p2_count", refresh_count, 1);

    // bounce then a press inside cooldown: only refresh at 52
    repeat (5) @(negedge clk);
    ref_edges.delete();
    for (int i = 0; i < 9; i++) begin
      care_btn = pat[i][0];
      @(negedge clk);
    end
    care_btn = 1'b0;
    @(negedge clk);
    care_btn = 1'b1;
    repeat (8) @(negedge clk);
    care_btn = 1'b0;
    repeat (10) @(negedge clk);
    check("p3_refresh_events", ref_edges.size(), 1);
    check("p3_refresh_cycle", (ref_edges.size() > 0) ? ref_edges[0] - base : -1, 52);
    check("p3_count", refresh_count, 2);

    // request lands on tick 75 -> refresh at 76
    tick_edges.delete();
    ref_edges.delete();
    care_btn = 1'b1;
    repeat (10) @(negedge clk);
    care_btn = 1'b0;
    repeat (5) @(negedge clk);
    check("p4_tick_cycle", (tick_edges.size() > 1) ? tick_edges[1] - base : -1, 75);
    check("p4_refresh_events", ref_edges.size(), 1);
    check("p4_refresh_cycle", (ref_edges.size() > 0) ? ref_edges[0] - base : -1, 76);
    check("p4_count", refresh_count, 3);

    // mood sequence
    for (int i = 0; i < 12; i++) begin
      value = 32'(mv[i]);
      @(negedge clk);
      check("p5_status", status, ms[i]);
      check("p5_alert", alert, ma[i]);
      @(negedge clk);
      check("p5_alert_hold", alert, 0);
    end

    // pause 7 cycles mid-period (ticks 110 then 122), then reset mid-debounce
    tick_edges.delete();
    repeat (4) @(negedge clk);
    pause = 1'b1;
    repeat (7) @(negedge clk);
    pause = 1'b0;
    repeat (4) @(negedge clk);
    care_btn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    care_btn = 1'b0;
    repeat (2) @(negedge clk);
    check("p6_tick_events", tick_edges.size(), 2);
    check("p6_tick_first", (tick_edges.size() > 0) ? tick_edges[0] - base : -1, 110);
    check("p6_tick_spacing", (tick_edges.size() > 1) ? tick_edges[1] - tick_edges[0] : -1, 12);
    check("p6_rst_outputs", {tick, refresh, alert, status, refresh_count}, 0);
    rst = 1'b0;
    base = cyc;
    tick_edges.delete();
    ref_edges.delete();
    repeat (16) @(negedge clk);
    check("p6_no_refresh", ref_edges.size(), 0);
    check("p6_count", refresh_count, 0);
    check("p6_status", status, 0);
    check("p6_tick_events", tick_edges.size(), 3);
    check("p6_tick_first", (tick_edges.size() > 0) ? tick_edges[0] - base : -1, 5);

    // randomized traffic against the model
    for (int k = 0; k < 700; k++) begin
      care_btn = 1'($urandom_range(0, 1));
      pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        value = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12));
      rst = ($urandom_range(0, 99) == 0);
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    rst = 1'b0;
    pause = 1'b0;
    care_btn = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
